mux_input_sequencer: RTL

Upstream operand-capture stage for the 4-bit 2:1 bus multiplexer. It debounces two push-buttons and loads the 4-bit slide-switch value alternately into operand registers A and B. It also toggles the select line, so its registered outputs drive the mux inputs A, B and Sel directly. All outputs are registered, so the mux sees glitch-free operands.

---
 rtl/mux_input_sequencer_pkg.sv | 7 +
 rtl/btn_debounce.sv | 32 +++
 rtl/mux_input_sequencer.sv | 65 ++++++
 3 files changed

// File: rtl/mux_input_sequencer_pkg.sv
// mux_input_sequencer_pkg: shared state encoding and debounce default for the operand sequencer
package mux_input_sequencer_pkg;
    typedef logic state_t;
    localparam state_t ST_LOAD_A = 1'b0;
    localparam state_t ST_LOAD_B = 1'b1;
    localparam int DB_LIMIT_DEFAULT = 50000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stability counter, pulses once per debounced press
module btn_debounce
    import mux_input_sequencer_pkg::*;
#(
    parameter int DB_LIMIT = DB_LIMIT_DEFAULT,
    parameter int DB_CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_state,
    output logic press
);
    logic [1:0] sync;
    logic [DB_CNT_W-1:0] cnt;
    logic hit;
    // The DB_LIMIT-th consecutive differing sample accepts the new level
    assign hit = (sync[1] != btn_state) && (cnt == DB_CNT_W'(DB_LIMIT - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            cnt       <= '0;
            btn_state <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync      <= {sync[0], btn_raw};
            cnt       <= (sync[1] == btn_state || hit) ? '0 : cnt + 1'b1;
            btn_state <= hit ? sync[1] : btn_state;
            press     <= hit & sync[1];
        end
    end
endmodule

// File: rtl/mux_input_sequencer.sv
// mux_input_sequencer: debounced buttons load sw alternately into A/B and toggle Sel
module mux_input_sequencer
    import mux_input_sequencer_pkg::*;
#(
    parameter int DB_LIMIT = DB_LIMIT_DEFAULT,
    parameter int DB_CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_sel,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       Sel,
    output logic       a_valid,
    output logic       b_valid,
    output logic       next_is_b
);
    state_t state, state_nxt;
    logic [3:0] sw_q;
    logic load_press, sel_press, load_state, sel_state, load_go, sel_go;

    btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_load (
        .clk(clk), .rst(rst), .btn_raw(btn_load), .btn_state(load_state), .press(load_press)
    );
    btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_db_sel (
        .clk(clk), .rst(rst), .btn_raw(btn_sel), .btn_state(sel_state), .press(sel_press)
    );

    // A press is only honoured while the debounced level is high
    assign load_go = load_press & load_state;
    assign sel_go  = sel_press & sel_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD_A;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = load_go ? ~state : state;
    end

    always_comb begin
        next_is_b = (state == ST_LOAD_B);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q    <= '0;
            A       <= '0;
            B       <= '0;
            Sel     <= 1'b0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            sw_q    <= sw;
            A       <= (load_go && state == ST_LOAD_A) ? sw_q : A;
            B       <= (load_go && state == ST_LOAD_B) ? sw_q : B;
            a_valid <= a_valid | (load_go && state == ST_LOAD_A);
            b_valid <= b_valid | (load_go && state == ST_LOAD_B);
            Sel     <= Sel ^ sel_go;
        end
    end
endmodule
